batcharger_ctrl: RTL

- Digital charge controller directly upstream of the 64-bit battery charger analog model.
- Consumes 8-bit ADC samples of battery voltage, current and temperature, plus programmed thresholds.
- Drives the charger's one-hot mode enables (tc, cc, cv) and the monitor enables that keep the ADC sampling.
- Sequences the charge profile TC -> CC -> CV -> END with debounce, a safety timer and a temperature cut-out.

---
 rtl/batcharger_pkg.sv | 28 ++
 rtl/batcharger_deb.sv | 32 +++
 rtl/batcharger_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/batcharger_pkg.sv
// Shared constants for the battery charge controller: state encoding,
// ADC code width and debounce counter width.
package batcharger_pkg;

  localparam int unsigned ADC_W = 8;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned ST_W  = 5;

  localparam int unsigned IDX_IDLE = 0;
  localparam int unsigned IDX_TC   = 1;
  localparam int unsigned IDX_CC   = 2;
  localparam int unsigned IDX_CV   = 3;
  localparam int unsigned IDX_END  = 4;

  localparam logic [ST_W-1:0] ST_IDLE = 5'b00001;
  localparam logic [ST_W-1:0] ST_TC   = 5'b00010;
  localparam logic [ST_W-1:0] ST_CC   = 5'b00100;
  localparam logic [ST_W-1:0] ST_CV   = 5'b01000;
  localparam logic [ST_W-1:0] ST_END  = 5'b10000;

  // Inclusive unsigned window test used for the temperature cut-out.
  function automatic logic in_window(input logic [ADC_W-1:0] x,
                                     input logic [ADC_W-1:0] lo,
                                     input logic [ADC_W-1:0] hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/batcharger_deb.sv
// Consecutive-sample debounce: qualifies a condition after DEB true samples
// in a row; any false sample or an explicit clear restarts the run.
module batcharger_deb
  import batcharger_pkg::*;
#(
  parameter int unsigned DEB = 4
) (
  input  logic clk,
  input  logic rstz,
  input  logic sample_valid,
  input  logic cond,
  input  logic clr,
  output logic qual_c
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  assign qual_c  = sample_valid && cond && (cnt_inc >= CNT_W'(DEB));

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (sample_valid) begin
      cnt <= cond ? cnt_inc : '0;
    end
  end

endmodule

// File: rtl/batcharger_ctrl.sv
// Charge profile sequencer TC -> CC -> CV -> END with debounced threshold
// exits, a saturating safety timer and a temperature cut-out.
module batcharger_ctrl
  import batcharger_pkg::*;
#(
  parameter int unsigned DEB = 4,
  parameter int unsigned TW  = 16
) (
  input  logic             clk,
  input  logic             rstz,
  input  logic             en,
  input  logic             sample_valid,
  input  logic [ADC_W-1:0] vbat,
  input  logic [ADC_W-1:0] ibat,
  input  logic [ADC_W-1:0] vtemp,
  input  logic [ADC_W-1:0] vcutoff,
  input  logic [ADC_W-1:0] vpreset,
  input  logic [ADC_W-1:0] vrech,
  input  logic [ADC_W-1:0] iend,
  input  logic [ADC_W-1:0] tempmin,
  input  logic [ADC_W-1:0] tempmax,
  input  logic [TW-1:0]    tmax,
  output logic             tc,
  output logic             cc,
  output logic             cv,
  output logic             monen,
  output logic             timeout,
  output logic             tfault
);

  logic [ST_W-1:0] state, state_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic [TW-1:0]   timer_inc;
  logic            timeout_nxt;
  logic            tfault_nxt;
  logic            temp_ok;
  logic            active;
  logic            tmr_exp;
  logic            thr_cond;
  logic            deb_cond;
  logic            deb_clr;
  logic            qual;

  assign temp_ok   = in_window(vtemp, tempmin, tempmax);
  assign active    = state[IDX_TC] | state[IDX_CC] | state[IDX_CV];
  assign timer_inc = (timer == '1) ? timer : timer + TW'(1);
  // Expiry counts the current sample, so tmax=N ends on the N-th active sample.
  assign tmr_exp   = (timer_inc >= tmax);

  // Exit condition of the current state, before debounce.
  always_comb begin
    thr_cond = 1'b0;
    unique case (state)
      ST_IDLE: thr_cond = (vbat < vcutoff);
      ST_TC:   thr_cond = (vbat >= vpreset);
      ST_CC:   thr_cond = (vbat >= vcutoff);
      ST_CV:   thr_cond = (ibat <= iend);
      ST_END:  thr_cond = (vbat < vrech);
      default: thr_cond = 1'b0;
    endcase
  end

  // A temperature fault breaks any run of qualifying samples.
  assign deb_cond = thr_cond && temp_ok;
  assign deb_clr  = !en || (state_nxt != state);

  batcharger_deb #(
    .DEB (DEB)
  ) u_deb (
    .clk          (clk),
    .rstz         (rstz),
    .sample_valid (sample_valid),
    .cond         (deb_cond),
    .clr          (deb_clr),
    .qual_c       (qual)
  );

  // Next state, timer and flags in priority order: enable, temperature, timer, thresholds.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    timeout_nxt = timeout;
    tfault_nxt  = tfault;

    if (!en) begin
      state_nxt   = ST_IDLE;
      timeout_nxt = 1'b0;
    end else if (sample_valid) begin
      tfault_nxt = !temp_ok;
      if (active) begin
        timer_nxt = timer_inc;
      end
      if (!temp_ok) begin
        state_nxt = ST_IDLE;
      end else if (active && tmr_exp) begin
        state_nxt   = ST_END;
        timeout_nxt = 1'b1;
      end else if (qual) begin
        unique case (state)
          ST_IDLE: state_nxt = (vbat < vpreset) ? ST_TC : ST_CC;
          ST_TC:   state_nxt = ST_CC;
          ST_CC:   state_nxt = ST_CV;
          ST_CV:   state_nxt = ST_END;
          ST_END: begin
            state_nxt   = ST_IDLE;
            timeout_nxt = 1'b0;
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
    end

    if (state_nxt == ST_IDLE) begin
      timer_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state   <= ST_IDLE;
      timer   <= '0;
      timeout <= 1'b0;
      tfault  <= 1'b0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      timeout <= timeout_nxt;
      tfault  <= tfault_nxt;
    end
  end

  assign tc    = state[IDX_TC];
  assign cc    = state[IDX_CC];
  assign cv    = state[IDX_CV];
  assign monen = en;

endmodule
